branch_compare_serial: RTL and testbench
========================================

Name: branch_compare_serial

Overview:
- Multi-cycle, bit-serial branch comparator: successor to the single-cycle branch comparison logic.
- Resolves RISC-V conditional branch conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU) over XLEN-wide operands, SLICE bits per cycle.
- Trades latency for area in the small-core configuration; sits between register-file read and the PC-select logic.
- Valid/ready handshakes, a tag passthrough and a pipeline-flush input.

Parameters:
- XLEN, 32, operand width in bits.
- SLICE, 8, bits compared per cycle; must divide XLEN; SLICE==XLEN gives single-cycle resolution.
- TAG_W, 5, width of the opaque tag carried from request to result.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of any in-flight or held comparison.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_0  in  XLEN  first operand (rs1).
- in_1  in  XLEN  second operand (rs2).
- mode  in  3  funct3 comparison code: EQ=000, NE=001, LT=100, GE=101, LTU=110, GEU=111.
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- branch  out  1  1 = condition true.
- out_tag  out  TAG_W  tag of the returned result.

Behaviour:
- Reset:
  - rst_n low asynchronously forces state IDLE.
  - in_ready=1, out_valid=0, branch=0, out_tag=0; internal flags and slice counter cleared.
  - Reset mid-operation discards the operation with no result.
- Clock and reset:
  - One clock (clk) and one reset (rst_n); reset is asynchronous, active-low.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_0, in_1, mode, in_tag; set eq=1, lt=0, cnt=0; go RUN.
  - RUN: in_ready=0, out_valid=0. Each edge processes slice cnt (bits [cnt*SLICE +: SLICE]), LSB slice first:
    - s_eq = (a_s == b_s)
    - s_lt = (a_s < b_s), unsigned, except the top slice under LT/GE, where it is a signed compare of the slices.
    - eq <= eq & s_eq; lt <= s_lt | (s_eq & lt); cnt <= cnt+1.
    - After the slice N-1 edge (N = XLEN/SLICE), go DONE with branch registered from the final eq/lt.
  - DONE: out_valid=1; branch and out_tag stable while out_ready=0. On out_valid&&out_ready, go IDLE (out_valid=0, in_ready=1 next cycle).
- Latency:
  - Result valid N cycles after the acceptance edge.
  - Throughput is one request per N+2 cycles with out_ready held high; there is no overlap between DONE and new acceptance.
- Result mapping:
  - EQ: eq. NE: !eq.
  - LT/LTU: lt. GE/GEU: !lt.
  - Any other code (010, 011): branch=0, same latency, no error flag.
- flush:
  - Synchronous and highest priority over all handshakes, in any state.
  - Next edge: IDLE, out_valid=0, branch=0; the request presented with flush is not accepted.
- Operand capture:
  - Input operand, mode and tag changes after acceptance have no effect.
  - out_tag equals the in_tag latched at acceptance.
- Internal width:
  - cnt width is clog2(N), minimum 1 bit; the final-slice detect is cnt==N-1, so no wrap-around is relied upon.

Test Plan (XLEN=32, SLICE=8, N=4):
1. EQ, in_0=in_1=0x12345678, tag=3 -> out_valid exactly 4 cycles after accept, branch=1, out_tag=3. The same with in_1=0x12345679 gives branch=0; NE gives branch=1.
2. in_0=0xFFFFFFFF, in_1=0x00000001 -> LT branch=1; GE 0; LTU 0; GEU 1.
3. in_0=0x01000000, in_1=0x00FFFFFF (lower slices favour in_1, top slice decides) -> LTU 0, GEU 1, LT 0. in_0=0x80000000, in_1=0x7FFFFFFF -> LT 1, LTU 0.
4. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid/branch/out_tag held and in_ready=0 throughout. Raise out_ready -> out_valid=0 and in_ready=1 on the next cycle.
5. flush asserted 2 cycles after accept -> out_valid never asserts, in_ready=1 next cycle. The following BLTU 5 vs 9 -> branch=1 after 4 cycles.
6. rst_n pulsed low mid-RUN (asynchronous, between edges) -> outputs return to reset values immediately. mode=010 with any operands -> branch=0 after 4 cycles.

Source files
------------

// File: rtl/branch_compare_serial_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_compare_serial_if
// Purpose  : Request/result handshake bundle for the bit-serial branch
//            comparator (operands, funct3 mode, tag, flush, result).
// Revision : 1.0 - initial release
// ============================================================================
interface branch_compare_serial_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_0;
    logic [XLEN-1:0]  in_1;
    logic [2:0]       mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             branch;
    logic [TAG_W-1:0] out_tag;

    // Requester / consumer side
    modport master (
        output flush, in_valid, in_0, in_1, mode, in_tag, out_ready,
        input  in_ready, out_valid, branch, out_tag
    );

    // Comparator side
    modport slave (
        input  flush, in_valid, in_0, in_1, mode, in_tag, out_ready,
        output in_ready, out_valid, branch, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/branch_compare_serial.sv
`default_nettype none
// ============================================================================
// Module   : branch_compare_serial
// Purpose  : Multi-cycle bit-serial RISC-V branch comparator. Resolves
//            BEQ/BNE/BLT/BGE/BLTU/BGEU over XLEN bits, SLICE bits per
//            cycle, LSB slice first, with valid/ready and flush.
// Revision : 1.0 - initial release
// ============================================================================
module branch_compare_serial #(
    parameter int XLEN  = 32,
    parameter int SLICE = 8,
    parameter int TAG_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    branch_compare_serial_if.slave  bus
);

    localparam int c_N  = XLEN / SLICE;
    localparam int c_CW = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic [2:0]       r_mode;
    logic [TAG_W-1:0] r_tag;
    logic             r_eq;
    logic             r_lt;
    logic [c_CW-1:0]  r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_branch;

    logic [SLICE-1:0] w_a_s;
    logic [SLICE-1:0] w_b_s;
    logic             w_last;
    logic             w_signed_cmp;
    logic             w_s_eq;
    logic             w_s_lt;
    logic             w_eq_nxt;
    logic             w_lt_nxt;

    // Map accumulated eq/lt flags to the branch decision for a funct3 code;
    // the two unused codes resolve to not-taken.
    function automatic logic resolve(input logic [2:0] m, input logic eq, input logic lt);
        logic res;
        case (m)
            3'b000:  res = eq;
            3'b001:  res = !eq;
            3'b100:  res = lt;
            3'b101:  res = !lt;
            3'b110:  res = lt;
            3'b111:  res = !lt;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Select the operand slice addressed by the slice counter.
    always_comb begin
        w_a_s = '0;
        w_b_s = '0;
        for (int k = 0; k < c_N; k++) begin
            if (r_cnt == c_CW'(k)) begin
                w_a_s = r_a[k*SLICE +: SLICE];
                w_b_s = r_b[k*SLICE +: SLICE];
            end
        end
    end

    // Per-slice compare; only the top slice of a signed compare treats its
    // MSB as a sign bit, all lower slices are magnitude digits.
    assign w_last       = (r_cnt == c_LAST);
    assign w_signed_cmp = w_last && (r_mode[2:1] == 2'b10);
    assign w_s_eq       = (w_a_s == w_b_s);
    assign w_s_lt       = w_signed_cmp ? ($signed(w_a_s) < $signed(w_b_s))
                                       : (w_a_s < w_b_s);
    // A more significant slice overrides the verdict of the lower ones
    // unless it is equal, in which case the lower verdict carries through.
    assign w_eq_nxt     = r_eq & w_s_eq;
    assign w_lt_nxt     = w_s_lt | (w_s_eq & r_lt);

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_mode      <= '0;
            r_tag       <= '0;
            r_eq        <= 1'b0;
            r_lt        <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_branch    <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= IDLE;
            r_eq        <= 1'b0;
            r_lt        <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_branch    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.in_0;
                        r_b        <= bus.in_1;
                        r_mode     <= bus.mode;
                        r_tag      <= bus.in_tag;
                        r_eq       <= 1'b1;
                        r_lt       <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_eq <= w_eq_nxt;
                    r_lt <= w_lt_nxt;
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_branch    <= resolve(r_mode, w_eq_nxt, w_lt_nxt);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_branch    <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_branch    <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.branch    = r_branch;
    assign bus.out_tag   = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_branch_compare_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_compare_serial
// Purpose  : Directed vector bench for branch_compare_serial (XLEN=32,
//            SLICE=8): table of compares plus backpressure, flush and
//            asynchronous reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_compare_serial;

    localparam int c_XLEN  = 32;
    localparam int c_SLICE = 8;
    localparam int c_TAG_W = 5;
    localparam int c_LAT   = c_XLEN / c_SLICE;

    logic clk;
    logic rst_n;

    branch_compare_serial_if #(.XLEN(c_XLEN), .TAG_W(c_TAG_W)) bus ();

    branch_compare_serial #(
        .XLEN  (c_XLEN),
        .SLICE (c_SLICE),
        .TAG_W (c_TAG_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  m;
        logic [4:0]  tag;
        logic        exp;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One full request/response with out_ready high. Starts and ends on a
    // negedge with the DUT idle.
    task automatic run_vec(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                           input logic [4:0] tag, input logic exp, input string name);
        int cyc;
        cyc = 0;
        while (!bus.in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_0     = a;
        bus.in_1     = b;
        bus.mode     = m;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        // scramble inputs: captured values must be unaffected
        bus.in_0     = ~a;
        bus.in_1     = ~b;
        bus.mode     = ~m;
        bus.in_tag   = ~tag;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, cyc, c_LAT);
        check({name, " branch"}, {31'd0, bus.branch}, {31'd0, exp});
        check({name, " out_tag"}, {27'd0, bus.out_tag}, {27'd0, tag});
        @(negedge clk);
        check({name, " ov_drop"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        int cyc;
        int seen;
        vecs[0]  = '{32'h12345678, 32'h12345678, 3'b000, 5'd3,  1'b1};
        vecs[1]  = '{32'h12345678, 32'h12345679, 3'b000, 5'd4,  1'b0};
        vecs[2]  = '{32'h12345678, 32'h12345679, 3'b001, 5'd5,  1'b1};
        vecs[3]  = '{32'hFFFFFFFF, 32'h00000001, 3'b100, 5'd6,  1'b1};
        vecs[4]  = '{32'hFFFFFFFF, 32'h00000001, 3'b101, 5'd7,  1'b0};
        vecs[5]  = '{32'hFFFFFFFF, 32'h00000001, 3'b110, 5'd8,  1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 32'h00000001, 3'b111, 5'd9,  1'b1};
        vecs[7]  = '{32'h01000000, 32'h00FFFFFF, 3'b110, 5'd10, 1'b0};
        vecs[8]  = '{32'h01000000, 32'h00FFFFFF, 3'b111, 5'd11, 1'b1};
        vecs[9]  = '{32'h01000000, 32'h00FFFFFF, 3'b100, 5'd12, 1'b0};
        vecs[10] = '{32'h80000000, 32'h7FFFFFFF, 3'b100, 5'd13, 1'b1};
        vecs[11] = '{32'h80000000, 32'h7FFFFFFF, 3'b110, 5'd14, 1'b0};
        vecs[12] = '{32'h00000010, 32'h00000020, 3'b100, 5'd15, 1'b1};
        vecs[13] = '{32'h00000005, 32'h00000005, 3'b101, 5'd16, 1'b1};
        vecs[14] = '{32'h00000005, 32'h00000005, 3'b100, 5'd17, 1'b0};
        vecs[15] = '{32'h00000000, 32'h00000000, 3'b001, 5'd31, 1'b0};
        vecs[16] = '{32'h00000000, 32'h00000000, 3'b011, 5'd18, 1'b0};

        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_0      = '0;
        bus.in_1      = '0;
        bus.mode      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst branch",    {31'd0, bus.branch},    32'd0);
        check("rst out_tag",   {27'd0, bus.out_tag},   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].tag, vecs[i].exp,
                    $sformatf("vec%0d", i));
        end

        // Backpressure: hold the result for five cycles.
        bus.out_ready = 1'b0;
        bus.in_0 = 32'hFFFFFFFF; bus.in_1 = 32'h00000001; bus.mode = 3'b100;
        bus.in_tag = 5'd21; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("bp latency", cyc, c_LAT);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp hold", {29'd0, bus.out_valid, bus.branch, bus.in_ready}, 32'b110);
            check("bp tag",  {27'd0, bus.out_tag}, 32'd21);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp release", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);

        // Flush two cycles after acceptance.
        bus.in_0 = 32'h1; bus.in_1 = 32'h1; bus.mode = 3'b000;
        bus.in_tag = 5'd22; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush in_ready", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check("flush no result", seen, 0);

        // Flush together with a request in IDLE: request must be dropped.
        bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        check("flush blocks accept", {31'd0, bus.in_ready}, 32'd1);
        run_vec(32'd5, 32'd9, 3'b110, 5'd23, 1'b1, "post-flush bltu");

        // Asynchronous reset between edges in the middle of RUN.
        bus.in_0 = 32'h7; bus.in_1 = 32'h7; bus.mode = 3'b000;
        bus.in_tag = 5'd25; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst outputs", {29'd0, bus.in_ready, bus.out_valid, bus.branch}, 32'b100);
        check("arst out_tag", {27'd0, bus.out_tag}, 32'd0);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check("arst no result", seen, 0);
        run_vec(32'hDEADBEEF, 32'h00000001, 3'b010, 5'd26, 1'b0, "mode010");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
